cpu_vga_reg_overlay: RTL and testbench



---
 rtl/cpu_vga_pkg.sv | 36 +++
 rtl/tcgrom.sv | 35 +++
 rtl/vga_reg_tracker.sv | 49 ++++
 rtl/cpu_vga_reg_overlay.sv | 193 +++++++++++++++++++
 tb/tb_cpu_vga_reg_overlay.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_vga_pkg.sv
// Shared constants and helpers for the CPU register text overlay.
package cpu_vga_pkg;

    // Character codes in the tcgrom glyph set
    localparam logic [5:0] CH_SPACE = 6'd32;
    localparam logic [5:0] CH_ZERO  = 6'd48;
    localparam logic [5:0] CH_R     = 6'd18;
    localparam logic [5:0] CH_HEX_A = 6'd1;

    // Pixel colours, {RR,GG,BB}
    localparam logic [5:0] COL_NORMAL  = 6'b110000;
    localparam logic [5:0] COL_CHANGED = 6'b111100;
    localparam logic [5:0] COL_BLACK   = 6'b000000;

    // Text grid layout
    localparam logic [4:0] LABEL_COL     = 5'd2;
    localparam logic [4:0] LABEL_NUM_COL = 5'd3;
    localparam logic [4:0] VALUE_COL     = 5'd5;
    localparam int         MAX_TEXT_COLS = 21;

    // Digit rendering mode latched once per frame
    typedef enum logic {
        MODE_BIN = 1'b0,
        MODE_HEX = 1'b1
    } digit_mode_e;

    // Map a 4-bit value to its glyph code: 0..9 are ASCII digits, A..F live at codes 1..6
    function automatic logic [5:0] digit_code(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return CH_ZERO + {2'b00, nibble};
        end else begin
            return CH_HEX_A + {2'b00, nibble} - 6'd10;
        end
    endfunction

endpackage

// File: rtl/tcgrom.sv
// 8x8 character ROM: address = {char code, glyph row}, row 0 at the top, MSB = leftmost pixel.
module tcgrom (
    input  logic [8:0] addr,
    output logic [7:0] data
);

    logic [63:0] glyph;

    // Look up the full 8-row glyph for the character, then pick the requested row
    always_comb begin
        glyph = 64'h0;
        case (addr[8:3])
            6'd1:  glyph = 64'h183C667E66666600; // A
            6'd2:  glyph = 64'h7C66667C66667C00; // B
            6'd3:  glyph = 64'h3C66606060663C00; // C
            6'd4:  glyph = 64'h786C6666666C7800; // D
            6'd5:  glyph = 64'h7E60607860607E00; // E
            6'd6:  glyph = 64'h7E60607860606000; // F
            6'd18: glyph = 64'h7C66667C786C6600; // R
            6'd48: glyph = 64'h3C666E7666663C00; // 0
            6'd49: glyph = 64'h1818381818187E00; // 1
            6'd50: glyph = 64'h3C66060C30607E00; // 2
            6'd51: glyph = 64'h3C66061C06663C00; // 3
            6'd52: glyph = 64'h060E1E667F060600; // 4
            6'd53: glyph = 64'h7E607C0606663C00; // 5
            6'd54: glyph = 64'h3C66607C66663C00; // 6
            6'd55: glyph = 64'h7E660C1818181800; // 7
            6'd56: glyph = 64'h3C66663C66663C00; // 8
            6'd57: glyph = 64'h3C66663E06663C00; // 9
            default: glyph = 64'h0;
        endcase
        data = glyph[{~addr[2:0], 3'b000} +: 8];
    end

endmodule

// File: rtl/vga_reg_tracker.sv
// Per-register frame snapshot plus change-highlight hold counter.
module vga_reg_tracker
    import cpu_vga_pkg::*;
#(
    parameter int REG_W       = 8,
    parameter int HOLD_FRAMES = 30
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             frame_start,
    input  logic [REG_W-1:0] reg_in,
    output logic [REG_W-1:0] snap,
    output logic             changed
);

    localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    logic [REG_W-1:0]  snap_q, snap_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    // On each frame start: take a new snapshot, reload the hold on change, otherwise count down to zero
    always_comb begin
        snap_d = snap_q;
        hold_d = hold_q;
        if (frame_start) begin
            snap_d = reg_in;
            if (reg_in != snap_q) begin
                hold_d = HOLD_W'(HOLD_FRAMES);
            end else if (hold_q != '0) begin
                hold_d = hold_q - HOLD_W'(1);
            end
        end
    end

    // Snapshot and hold counter state
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            snap_q <= '0;
            hold_q <= '0;
        end else begin
            snap_q <= snap_d;
            hold_q <= hold_d;
        end
    end

    assign snap    = snap_q;
    assign changed = (hold_q != '0);

endmodule

// File: rtl/cpu_vga_reg_overlay.sv
// Text overlay drawing N_REGS debug registers (binary or hex) into a 3-stage VGA pixel pipeline.
module cpu_vga_reg_overlay
    import cpu_vga_pkg::*;
#(
    parameter int N_REGS      = 8,
    parameter int REG_W       = 8,
    parameter int HOLD_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    clear_n,
    input  logic [10:0]             XPos,
    input  logic [9:0]              YPos,
    input  logic                    Valid,
    input  logic                    frame_start,
    input  logic                    hex_mode,
    input  logic [N_REGS*REG_W-1:0] reg_bus,
    output logic [5:0]              vga_rgb
);

    localparam int HEX_DIGITS = (REG_W + 3) / 4;
    localparam int PAD_W      = HEX_DIGITS * 4;

    if (N_REGS < 1 || N_REGS > 10) begin : g_bad_n_regs
        $error("cpu_vga_reg_overlay: N_REGS must be 1..10");
    end
    if (REG_W < 1 || REG_W > 16) begin : g_bad_reg_w
        $error("cpu_vga_reg_overlay: REG_W must be 1..16");
    end
    if (int'(VALUE_COL) + REG_W > MAX_TEXT_COLS) begin : g_bad_width
        $error("cpu_vga_reg_overlay: value digits overflow the text line");
    end

    logic [REG_W-1:0] snap [N_REGS];
    logic [N_REGS-1:0] changed;

    for (genvar i = 0; i < N_REGS; i++) begin : g_reg
        vga_reg_tracker #(
            .REG_W       (REG_W),
            .HOLD_FRAMES (HOLD_FRAMES)
        ) u_tracker (
            .clk         (clk),
            .clear_n     (clear_n),
            .frame_start (frame_start),
            .reg_in      (reg_bus[i*REG_W +: REG_W]),
            .snap        (snap[i]),
            .changed     (changed[i])
        );
    end

    digit_mode_e hex_q, hex_d;

    logic [5:0] code_q, code_d;
    logic [5:0] colour_q, colour_d;
    logic [2:0] row_q, row_d;
    logic [2:0] bit_q, bit_d;
    logic       valid_q, valid_d;

    logic [7:0] glyph_q, glyph_d;
    logic [5:0] colour2_q, colour2_d;
    logic [2:0] bit2_q, bit2_d;
    logic       valid2_q, valid2_d;

    logic [5:0] rgb_q, rgb_d;

    logic [4:0]       text_col;
    logic [4:0]       text_row;
    logic [3:0]       reg_idx;
    logic [4:0]       digit_pos;
    logic             row_hit;
    logic             sel_chg;
    logic [REG_W-1:0] sel_snap;
    logic [PAD_W-1:0] padded;
    logic [5:0]       bin_code;
    logic [5:0]       hex_code;
    logic [7:0]       rom_data;
    logic             unused_bits;

    assign text_col    = XPos[10:6];
    assign text_row    = YPos[9:5];
    assign reg_idx     = text_row[4:1];
    assign digit_pos   = text_col - VALUE_COL;
    assign unused_bits = ^{XPos[2:0], YPos[1:0]};

    // Display mode only changes at frame start so a frame never mixes radices
    always_comb begin
        hex_d = hex_q;
        if (frame_start) begin
            hex_d = digit_mode_e'(hex_mode);
        end
    end

    // Find which register (if any) owns the current odd text row
    always_comb begin
        row_hit  = 1'b0;
        sel_chg  = 1'b0;
        sel_snap = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (text_row[0] && reg_idx == 4'(i)) begin
                row_hit  = 1'b1;
                sel_snap = snap[i];
                sel_chg  = changed[i];
            end
        end
    end

    // Glyph code for the current value digit in both radices
    always_comb begin
        bin_code = CH_SPACE;
        hex_code = CH_SPACE;
        padded   = PAD_W'(sel_snap);
        for (int k = 0; k < REG_W; k++) begin
            if (digit_pos == 5'(k)) begin
                bin_code = digit_code({3'b000, sel_snap[REG_W-1-k]});
            end
        end
        for (int k = 0; k < HEX_DIGITS; k++) begin
            if (digit_pos == 5'(k)) begin
                hex_code = digit_code(padded[(HEX_DIGITS-1-k)*4 +: 4]);
            end
        end
    end

    // Stage 1: choose the character for this cell and its colour
    always_comb begin
        code_d   = CH_SPACE;
        colour_d = (row_hit && sel_chg) ? COL_CHANGED : COL_NORMAL;
        row_d    = YPos[4:2];
        bit_d    = XPos[5:3];
        valid_d  = Valid;
        if (row_hit) begin
            if (text_col == LABEL_COL) begin
                code_d = CH_R;
            end else if (text_col == LABEL_NUM_COL) begin
                code_d = CH_ZERO + {2'b00, reg_idx};
            end else if (text_col >= VALUE_COL) begin
                code_d = (hex_q == MODE_HEX) ? hex_code : bin_code;
            end
        end
    end

    tcgrom u_rom (
        .addr (({code_q, row_q})),
        .data (rom_data)
    );

    // Stage 2: capture the glyph row and carry pixel attributes alongside it
    always_comb begin
        glyph_d   = rom_data;
        colour2_d = colour_q;
        bit2_d    = bit_q;
        valid2_d  = valid_q;
    end

    // Stage 3: pick the glyph pixel and gate it by the visible-area flag
    always_comb begin
        rgb_d = COL_BLACK;
        if (valid2_q && glyph_q[3'd7 - bit2_q]) begin
            rgb_d = colour2_q;
        end
    end

    // Pipeline and mode registers
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            hex_q     <= MODE_BIN;
            code_q    <= '0;
            colour_q  <= '0;
            row_q     <= '0;
            bit_q     <= '0;
            valid_q   <= 1'b0;
            glyph_q   <= '0;
            colour2_q <= '0;
            bit2_q    <= '0;
            valid2_q  <= 1'b0;
            rgb_q     <= '0;
        end else begin
            hex_q     <= hex_d;
            code_q    <= code_d;
            colour_q  <= colour_d;
            row_q     <= row_d;
            bit_q     <= bit_d;
            valid_q   <= valid_d;
            glyph_q   <= glyph_d;
            colour2_q <= colour2_d;
            bit2_q    <= bit2_d;
            valid2_q  <= valid2_d;
            rgb_q     <= rgb_d;
        end
    end

    assign vga_rgb = rgb_q;

endmodule

// File: tb/tb_cpu_vga_reg_overlay.sv
// Directed bench for cpu_vga_reg_overlay: one 8x8 instance with a short hold, one 10x16 corner instance.
module tb_cpu_vga_reg_overlay;

    localparam logic [5:0] RED = 6'b110000;
    localparam logic [5:0] YEL = 6'b111100;
    localparam logic [5:0] BLK = 6'b000000;

    logic         clk = 1'b0;
    logic         clear_n;
    logic [10:0]  XPos;
    logic [9:0]   YPos;
    logic         Valid;
    logic         frame_start;
    logic         hex_mode;
    logic [63:0]  reg_bus_a;
    logic [159:0] reg_bus_b;
    logic [5:0]   rgb_a;
    logic [5:0]   rgb_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_vga_reg_overlay #(.N_REGS(8), .REG_W(8), .HOLD_FRAMES(2)) dut_a (
        .clk(clk), .clear_n(clear_n), .XPos(XPos), .YPos(YPos), .Valid(Valid),
        .frame_start(frame_start), .hex_mode(hex_mode), .reg_bus(reg_bus_a), .vga_rgb(rgb_a)
    );

    cpu_vga_reg_overlay #(.N_REGS(10), .REG_W(16), .HOLD_FRAMES(30)) dut_b (
        .clk(clk), .clear_n(clear_n), .XPos(XPos), .YPos(YPos), .Valid(Valid),
        .frame_start(frame_start), .hex_mode(hex_mode), .reg_bus(reg_bus_b), .vga_rgb(rgb_b)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Present one pixel and return both outputs three edges later
    task automatic sample(input logic [10:0] x, input logic [9:0] y, input logic v,
                          output logic [5:0] ra, output logic [5:0] rb);
        XPos  = x;
        YPos  = y;
        Valid = v;
        repeat (3) @(posedge clk);
        #1;
        ra = rgb_a;
        rb = rgb_b;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] ra, rb;
        clear_n = 1'b0;
        XPos = 11'd136; YPos = 10'd32; Valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (rgb_a !== BLK || rgb_b !== BLK) begin
            errors++; $display("[TB] FAIL reset_state got %b/%b want %b", rgb_a, rgb_b, BLK);
        end
        clear_n = 1'b1;
        sample(11'd136, 10'd32, 1'b1, ra, rb);
        checks++;
        if (ra !== RED) begin errors++; $display("[TB] FAIL reset_label_R got %b want %b", ra, RED); end
        sample(11'd328, 10'd36, 1'b1, ra, rb);
        checks++;
        if (ra !== RED) begin errors++; $display("[TB] FAIL reset_zero_lit got %b want %b", ra, RED); end
        sample(11'd320, 10'd36, 1'b1, ra, rb);
        checks++;
        if (ra !== BLK) begin errors++; $display("[TB] FAIL reset_zero_dark got %b want %b", ra, BLK); end
        sample(11'd328, 10'd36, 1'b0, ra, rb);
        checks++;
        if (ra !== BLK) begin errors++; $display("[TB] FAIL valid_gate got %b want %b", ra, BLK); end
        sample(11'd328, 10'd36, 1'b1, ra, rb);
        clear_n = 1'b0;
        #1;
        checks++;
        if (rgb_a !== BLK) begin errors++; $display("[TB] FAIL reset_async got %b want %b", rgb_a, BLK); end
        @(posedge clk);
        #1;
        clear_n = 1'b1;
        sample(11'd328, 10'd36, 1'b1, ra, rb);
        checks++;
        if (ra !== RED) begin errors++; $display("[TB] FAIL reset_resume got %b want %b", ra, RED); end
    endtask

    task automatic test_reset_frame();
        logic [5:0] ra, rb;
        reg_bus_a[3*8 +: 8] = 8'hFF;
        clear_n = 1'b0;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        clear_n = 1'b1;
        sample(11'd336, 10'd224, 1'b1, ra, rb);
        checks++;
        if (ra !== RED) begin errors++; $display("[TB] FAIL reset_wins got %b want %b", ra, RED); end
        pulse_frame();
        sample(11'd336, 10'd224, 1'b1, ra, rb);
        checks++;
        if (ra !== BLK) begin errors++; $display("[TB] FAIL first_frame_digit got %b want %b", ra, BLK); end
        sample(11'd344, 10'd224, 1'b1, ra, rb);
        checks++;
        if (ra !== YEL) begin errors++; $display("[TB] FAIL first_frame_hilite got %b want %b", ra, YEL); end
        sample(11'd336, 10'd32, 1'b1, ra, rb);
        checks++;
        if (ra !== RED) begin errors++; $display("[TB] FAIL first_frame_zero_red got %b want %b", ra, RED); end
    endtask

    task automatic test_binary();
        logic [5:0] ra, rb, exp;
        logic [7:0] val;
        val = 8'hA5;
        reg_bus_a[2*8 +: 8] = val;
        pulse_frame();
        for (int k = 0; k < 8; k++) begin
            exp = val[7-k] ? BLK : YEL;
            sample(11'((5 + k) * 64 + 16), 10'd160, 1'b1, ra, rb);
            checks++;
            if (ra !== exp) begin
                errors++; $display("[TB] FAIL binary_col%0d got %b want %b", 5 + k, ra, exp);
            end
        end
        sample(11'd856, 10'd160, 1'b1, ra, rb);
        checks++;
        if (ra !== BLK) begin errors++; $display("[TB] FAIL binary_trailing_space got %b want %b", ra, BLK); end
    endtask

    task automatic test_latency();
        XPos = 11'd344; YPos = 10'd160; Valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        Valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rgb_a !== BLK) begin errors++; $display("[TB] FAIL latency_early got %b want %b", rgb_a, BLK); end
        @(posedge clk);
        #1;
        checks++;
        if (rgb_a !== YEL) begin errors++; $display("[TB] FAIL latency_on got %b want %b", rgb_a, YEL); end
        Valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rgb_a !== YEL) begin errors++; $display("[TB] FAIL latency_tail got %b want %b", rgb_a, YEL); end
        @(posedge clk);
        #1;
        checks++;
        if (rgb_a !== BLK) begin errors++; $display("[TB] FAIL latency_off got %b want %b", rgb_a, BLK); end
    endtask

    task automatic test_hex();
        logic [5:0] ra, rb;
        hex_mode = 1'b1;
        reg_bus_a[2*8 +: 8] = 8'h3C;
        pulse_frame();
        hex_mode = 1'b0;
        sample(11'd360, 10'd168, 1'b1, ra, rb);
        checks++;
        if (ra !== YEL) begin errors++; $display("[TB] FAIL hex_3_lit got %b want %b", ra, YEL); end
        sample(11'd328, 10'd168, 1'b1, ra, rb);
        checks++;
        if (ra !== BLK) begin errors++; $display("[TB] FAIL hex_3_dark got %b want %b", ra, BLK); end
        sample(11'd392, 10'd168, 1'b1, ra, rb);
        checks++;
        if (ra !== YEL) begin errors++; $display("[TB] FAIL hex_C_lit got %b want %b", ra, YEL); end
        sample(11'd424, 10'd168, 1'b1, ra, rb);
        checks++;
        if (ra !== BLK) begin errors++; $display("[TB] FAIL hex_C_dark got %b want %b", ra, BLK); end
        sample(11'd456, 10'd168, 1'b1, ra, rb);
        checks++;
        if (ra !== BLK) begin errors++; $display("[TB] FAIL hex_col7_space got %b want %b", ra, BLK); end
    endtask

    task automatic test_hold();
        logic [5:0] ra, rb;
        reg_bus_a[1*8 +: 8] = 8'h07;
        pulse_frame();
        sample(11'd336, 10'd96, 1'b1, ra, rb);
        checks++;
        if (ra !== YEL) begin errors++; $display("[TB] FAIL hold_f1 got %b want %b", ra, YEL); end
        pulse_frame();
        sample(11'd336, 10'd96, 1'b1, ra, rb);
        checks++;
        if (ra !== YEL) begin errors++; $display("[TB] FAIL hold_f2 got %b want %b", ra, YEL); end
        pulse_frame();
        sample(11'd336, 10'd96, 1'b1, ra, rb);
        checks++;
        if (ra !== RED) begin errors++; $display("[TB] FAIL hold_f3 got %b want %b", ra, RED); end
        reg_bus_a[1*8 +: 8] = 8'h27;
        pulse_frame();
        reg_bus_a[1*8 +: 8] = 8'h37;
        pulse_frame();
        pulse_frame();
        sample(11'd336, 10'd96, 1'b1, ra, rb);
        checks++;
        if (ra !== YEL) begin errors++; $display("[TB] FAIL reload_f3 got %b want %b", ra, YEL); end
        pulse_frame();
        sample(11'd336, 10'd96, 1'b1, ra, rb);
        checks++;
        if (ra !== RED) begin errors++; $display("[TB] FAIL reload_f4 got %b want %b", ra, RED); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ra, rb;
        reg_bus_a[1*8 +: 8] = 8'h55;
        pulse_frame();
        sample(11'd336, 10'd96, 1'b1, ra, rb);
        checks++;
        if (ra !== YEL) begin errors++; $display("[TB] FAIL b2b_load got %b want %b", ra, YEL); end
        frame_start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        frame_start = 1'b0;
        sample(11'd336, 10'd96, 1'b1, ra, rb);
        checks++;
        if (ra !== RED) begin errors++; $display("[TB] FAIL b2b_two_frames got %b want %b", ra, RED); end
        pulse_frame();
        sample(11'd336, 10'd96, 1'b1, ra, rb);
        checks++;
        if (ra !== RED) begin errors++; $display("[TB] FAIL b2b_saturate got %b want %b", ra, RED); end
    endtask

    task automatic test_snapshot();
        logic [5:0] ra, rb;
        reg_bus_a[4*8 +: 8] = 8'hFF;
        sample(11'd336, 10'd288, 1'b1, ra, rb);
        checks++;
        if (ra !== RED) begin errors++; $display("[TB] FAIL snap_held got %b want %b", ra, RED); end
        pulse_frame();
        sample(11'd336, 10'd288, 1'b1, ra, rb);
        checks++;
        if (ra !== BLK) begin errors++; $display("[TB] FAIL snap_new_dark got %b want %b", ra, BLK); end
        sample(11'd344, 10'd288, 1'b1, ra, rb);
        checks++;
        if (ra !== YEL) begin errors++; $display("[TB] FAIL snap_new_lit got %b want %b", ra, YEL); end
    endtask

    task automatic test_corner();
        logic [5:0] ra, rb;
        reg_bus_b[9*16 +: 16] = 16'h8001;
        pulse_frame();
        sample(11'd136, 10'd608, 1'b1, ra, rb);
        checks++;
        if (rb !== YEL) begin errors++; $display("[TB] FAIL corner_label_R got %b want %b", rb, YEL); end
        checks++;
        if (ra !== BLK) begin errors++; $display("[TB] FAIL small_no_row19 got %b want %b", ra, BLK); end
        sample(11'd200, 10'd620, 1'b1, ra, rb);
        checks++;
        if (rb !== BLK) begin errors++; $display("[TB] FAIL corner_9_dark got %b want %b", rb, BLK); end
        sample(11'd240, 10'd620, 1'b1, ra, rb);
        checks++;
        if (rb !== YEL) begin errors++; $display("[TB] FAIL corner_9_lit got %b want %b", rb, YEL); end
        sample(11'd344, 10'd608, 1'b1, ra, rb);
        checks++;
        if (rb !== YEL) begin errors++; $display("[TB] FAIL corner_msb_lit got %b want %b", rb, YEL); end
        sample(11'd336, 10'd608, 1'b1, ra, rb);
        checks++;
        if (rb !== BLK) begin errors++; $display("[TB] FAIL corner_msb_dark got %b want %b", rb, BLK); end
        sample(11'd1232, 10'd608, 1'b1, ra, rb);
        checks++;
        if (rb !== YEL) begin errors++; $display("[TB] FAIL corner_col19 got %b want %b", rb, YEL); end
        sample(11'd1304, 10'd608, 1'b1, ra, rb);
        checks++;
        if (rb !== YEL) begin errors++; $display("[TB] FAIL corner_lsb_lit got %b want %b", rb, YEL); end
        sample(11'd1296, 10'd608, 1'b1, ra, rb);
        checks++;
        if (rb !== BLK) begin errors++; $display("[TB] FAIL corner_lsb_dark got %b want %b", rb, BLK); end
        sample(11'd16, 10'd608, 1'b1, ra, rb);
        checks++;
        if (rb !== BLK) begin errors++; $display("[TB] FAIL corner_col0 got %b want %b", rb, BLK); end
        sample(11'd88, 10'd608, 1'b1, ra, rb);
        checks++;
        if (rb !== BLK) begin errors++; $display("[TB] FAIL corner_col1 got %b want %b", rb, BLK); end
        sample(11'd280, 10'd608, 1'b1, ra, rb);
        checks++;
        if (rb !== BLK) begin errors++; $display("[TB] FAIL corner_col4 got %b want %b", rb, BLK); end
        sample(11'd336, 10'd32, 1'b1, ra, rb);
        checks++;
        if (rb !== RED) begin errors++; $display("[TB] FAIL corner_r0_red got %b want %b", rb, RED); end
    endtask

    initial begin
        clear_n     = 1'b0;
        XPos        = '0;
        YPos        = '0;
        Valid       = 1'b0;
        frame_start = 1'b0;
        hex_mode    = 1'b0;
        reg_bus_a   = '0;
        reg_bus_b   = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_reset_frame();
        test_binary();
        test_latency();
        test_hex();
        test_hold();
        test_back_to_back();
        test_snapshot();
        test_corner();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
